// File: rtl/alu_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_fetch
// Description : 32-entry register file with same-cycle write-back bypass and
//               a single registered operand stage toward the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_fetch #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  input  logic [1:0]       op_in,
  input  logic             binvert_in,
  input  logic             cin_in,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [1:0]       op,
  output logic             binvert,
  output logic             cin,
  output logic [4:0]       out_rd
);

  logic [WIDTH-1:0] r_rf [32];
  logic             r_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic             r_binvert;
  logic             r_cin;
  logic [4:0]       r_rd;

  logic             w_fire;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // Write-back data is forwarded so an instruction issuing in the same cycle
  // as the write sees the new value.
  always_comb begin
    w_a = '0;
    w_b = '0;
    if (rs1 != 5'd0) begin
      w_a = (wb_en && (wb_addr == rs1)) ? wb_data : r_rf[rs1];
    end
    if (rs2 != 5'd0) begin
      w_b = (wb_en && (wb_addr == rs2)) ? wb_data : r_rf[rs2];
    end
  end

  assign in_ready = !r_valid || out_ready;
  assign w_fire   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= 2'd0;
      r_binvert <= 1'b0;
      r_cin     <= 1'b0;
      r_rd      <= 5'd0;
    end else if (w_fire) begin
      r_valid   <= 1'b1;
      r_a       <= w_a;
      r_b       <= w_b;
      r_op      <= op_in;
      r_binvert <= binvert_in;
      r_cin     <= cin_in;
      r_rd      <= rd;
    end else if (out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign a         = r_a;
  assign b         = r_b;
  assign op        = r_op;
  assign binvert   = r_binvert;
  assign cin       = r_cin;
  assign out_rd    = r_rd;

endmodule
`default_nettype wire

// File: doc/alu_operand_fetch.md
ALU_OPERAND_FETCH -- requirements
Module: alu_operand_fetch

Interface
REQ-001 Parameter: WIDTH, 32, data width of register file entries and ALU operands.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream instruction fields valid this cycle.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 rs1, rs2  input  5 each  source register addresses.
REQ-007 rd  input  5  destination register address, passed through.
REQ-008 op_in  input  2  ALU operation select, passed through.
REQ-009 binvert_in, cin_in  input  1 each  ALU b-invert and carry-in, passed through.
REQ-010 wb_en  input  1  write-back strobe.
REQ-011 wb_addr  input  5  write-back register address.
REQ-012 wb_data  input  WIDTH  write-back data.
REQ-013 out_valid  output  1  operand bundle valid toward ALU.
REQ-014 out_ready  input  1  downstream consumes bundle this cycle.
REQ-015 a, b  output  WIDTH each  registered ALU operands.
REQ-016 op, binvert, cin, out_rd  output  2/1/1/5  registered pass-through fields.

Function
REQ-017 Register file: 32 entries x WIDTH; entry 0 reads as 0 always; writes to entry 0 ignored.
REQ-018 Write: on rising edge with wb_en=1 and wb_addr!=0, entry wb_addr <= wb_data.
REQ-019 in_ready = !out_valid || out_ready (combinational; single output stage, no skid buffer).
REQ-020 Issue: fire = in_valid && in_ready; on fire, a/b/op/binvert/cin/out_rd load and out_valid <= 1; latency exactly 1 cycle.
REQ-021 Operand select per port: addr==0 -> 0; else wb_en && wb_addr==addr -> wb_data (same-cycle bypass); else stored entry.
REQ-022 rs1==rs2 with bypass active: a and b both equal wb_data.
REQ-023 Consume without new fire (out_valid && out_ready && !in_valid): out_valid <= 0; a/b/pass-through fields hold last value.
REQ-024 Stall (out_valid && !out_ready): all outputs hold stable; in_ready=0; no fire.
REQ-025 Held operands are captured at issue; write-back during stall does not alter held a/b.
REQ-026 Simultaneous consume and fire: out_valid stays 1, new bundle replaces old, no bubble.
REQ-027 Write-back is independent of handshake; it proceeds during stall and while in_valid=0.
REQ-028 No combinational path from in_valid or register file to a/b/out_valid.

Reset
REQ-029 rst_n=0 asynchronously clears all 32 entries, out_valid, a, b, op, binvert, cin, out_rd to 0.
REQ-030 Reset mid-operation discards any pending bundle; no write-back occurs while rst_n=0.
REQ-031 After rst_n deasserts, in_ready=1 and first fire may occur on the next rising edge.

Verification
REQ-032 Write 0x0000_00AA to r3, next cycle issue rs1=3, rs2=0, op=2 -> after 1 cycle a=0x0000_00AA, b=0, op=2, out_valid=1.
REQ-033 Same-cycle bypass: wb_en=1, wb_addr=7, wb_data=0xDEAD_BEEF with fire rs1=7, rs2=7 -> a=b=0xDEAD_BEEF.
REQ-034 Write 0xFFFF_FFFF to r0, then issue rs1=0 -> a=0; r0 never nonzero.
REQ-035 Stall: out_ready=0 for 3 cycles with in_valid=1 and write-back to held rs1 -> in_ready=0, a/b unchanged, new bundle issues the cycle after out_ready=1 with updated value.
REQ-036 Back-to-back: in_valid=1, out_ready=1 for 4 cycles with rs1=1..4 -> out_valid=1 continuously, a tracks r1..r4 one cycle late.
REQ-037 Assert rst_n=0 mid-stall with out_valid=1 -> out_valid, a, b drop to 0 immediately; subsequent read of any previously written register returns 0.
